// File: rtl/ex_issue_stage.sv
// ex_issue_stage: ID/EX issue stage in front of the 32-bit ALU.
// Decodes the ALU control code, picks src2 (rt or sign-extended immediate),
// and holds results in a main register plus a skid register so the ALU
// inputs are registered and backpressure never drops or reorders work.
module ex_issue_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_aluop,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_alusrc,
  input  logic [4:0]        in_rd,
  input  logic              in_regwrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_src1,
  output logic [DATA_W-1:0] out_src2,
  output logic [3:0]        out_alu_control,
  output logic [4:0]        out_rd,
  output logic              out_regwrite,
  output logic              out_illegal
);

  logic [3:0]        w_ctrl;
  logic              w_illegal;
  logic              w_regwrite;
  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_src2;
  logic              w_accept;
  logic              w_drain;
  logic              w_main_free;

  // Main entry: drives every out_* signal directly.
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_src1;
  logic [DATA_W-1:0] r_m_src2;
  logic [3:0]        r_m_ctrl;
  logic [4:0]        r_m_rd;
  logic              r_m_regwrite;
  logic              r_m_illegal;

  // Skid entry: catches one instruction while main is stalled.
  logic              r_s_valid;
  logic [DATA_W-1:0] r_s_src1;
  logic [DATA_W-1:0] r_s_src2;
  logic [3:0]        r_s_ctrl;
  logic [4:0]        r_s_rd;
  logic              r_s_regwrite;
  logic              r_s_illegal;

  // in_ready comes straight from a flop: room exists whenever skid is empty.
  assign in_ready    = ~r_s_valid;
  assign w_accept    = in_valid & in_ready;
  assign w_drain     = r_m_valid & out_ready;
  assign w_main_free = ~r_m_valid | w_drain;

  assign w_imm_ext  = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign w_src2     = in_alusrc ? w_imm_ext : in_rt_data;
  assign w_regwrite = in_regwrite & ~w_illegal;

  // ALU control decode; unknown R-type functs fall back to add and are flagged.
  always_comb begin
    w_ctrl    = 4'b0010;
    w_illegal = 1'b0;
    case (in_aluop)
      2'b00: w_ctrl = 4'b0010;
      2'b01: w_ctrl = 4'b0110;
      2'b11: w_ctrl = 4'b0111;
      default: begin
        case (in_funct)
          6'b100000: w_ctrl = 4'b0010;
          6'b100010: w_ctrl = 4'b0110;
          6'b100100: w_ctrl = 4'b0000;
          6'b100101: w_ctrl = 4'b0001;
          6'b101010: w_ctrl = 4'b0111;
          6'b100111: w_ctrl = 4'b1100;
          default: begin
            w_ctrl    = 4'b0010;
            w_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Main register: refill from skid first (FIFO order), else from the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid    <= 1'b0;
      r_m_src1     <= '0;
      r_m_src2     <= '0;
      r_m_ctrl     <= 4'b0000;
      r_m_rd       <= 5'd0;
      r_m_regwrite <= 1'b0;
      r_m_illegal  <= 1'b0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_s_valid) begin
        r_m_valid    <= 1'b1;
        r_m_src1     <= r_s_src1;
        r_m_src2     <= r_s_src2;
        r_m_ctrl     <= r_s_ctrl;
        r_m_rd       <= r_s_rd;
        r_m_regwrite <= r_s_regwrite;
        r_m_illegal  <= r_s_illegal;
      end else if (w_accept) begin
        r_m_valid    <= 1'b1;
        r_m_src1     <= in_rs_data;
        r_m_src2     <= w_src2;
        r_m_ctrl     <= w_ctrl;
        r_m_rd       <= in_rd;
        r_m_regwrite <= w_regwrite;
        r_m_illegal  <= w_illegal;
      end else begin
        r_m_valid <= 1'b0;
      end
    end
  end

  // Skid register: loads only when main is full and stalled; empties when main frees up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_valid    <= 1'b0;
      r_s_src1     <= '0;
      r_s_src2     <= '0;
      r_s_ctrl     <= 4'b0000;
      r_s_rd       <= 5'd0;
      r_s_regwrite <= 1'b0;
      r_s_illegal  <= 1'b0;
    end else if (flush) begin
      r_s_valid <= 1'b0;
    end else if (w_main_free) begin
      r_s_valid <= 1'b0;
    end else if (w_accept) begin
      r_s_valid    <= 1'b1;
      r_s_src1     <= in_rs_data;
      r_s_src2     <= w_src2;
      r_s_ctrl     <= w_ctrl;
      r_s_rd       <= in_rd;
      r_s_regwrite <= w_regwrite;
      r_s_illegal  <= w_illegal;
    end
  end

  assign out_valid       = r_m_valid;
  assign out_src1        = r_m_src1;
  assign out_src2        = r_m_src2;
  assign out_alu_control = r_m_ctrl;
  assign out_rd          = r_m_rd;
  assign out_regwrite    = r_m_regwrite;
  assign out_illegal     = r_m_illegal;

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the 32-bit ALU.
- Accepts decoded-instruction fields from ID over a valid/ready handshake.
- Generates the 4-bit ALU control code and selects the second operand (register or sign-extended immediate).
- Holds the result in a 2-entry skid buffer, so the ALU's src1/src2/ALU_control inputs come straight from registers and EX backpressure never drops or reorders instructions.

Parameters:
- DATA_W, 32, operand width (ALU is 32-bit; only 32 is required to work).
- IMM_W, 16, immediate field width; sign-extended to DATA_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  ID presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_aluop  input  2  00 = mem add, 01 = branch sub, 10 = R-type, 11 = slti.
- in_funct  input  6  R-type funct field.
- in_rs_data  input  DATA_W  rs register value.
- in_rt_data  input  DATA_W  rt register value.
- in_imm  input  IMM_W  immediate field.
- in_alusrc  input  1  1 = use the immediate as src2.
- in_rd  input  5  destination register.
- in_regwrite  input  1  writeback enable.
- out_valid  output  1  held instruction valid toward the ALU.
- out_ready  input  1  EX consumes this cycle.
- out_src1  output  DATA_W  ALU src1.
- out_src2  output  DATA_W  ALU src2.
- out_alu_control  output  4  ALU_control.
- out_rd  output  5  destination register.
- out_regwrite  output  1  writeback enable, gated by legality.
- out_illegal  output  1  unsupported funct flag.

Behaviour:
- Reset (rst_n low, asynchronous): both entries invalid; all output data registers 0; out_alu_control = 0000; in_ready = 1 after release.
- Decode (combinational on input fields, captured at accept):
  - aluop 00 -> 0010.
  - aluop 01 -> 0110.
  - aluop 11 -> 0111.
  - aluop 10, funct 100000 -> 0010 (add).
  - aluop 10, funct 100010 -> 0110 (sub).
  - aluop 10, funct 100100 -> 0000 (and).
  - aluop 10, funct 100101 -> 0001 (or).
  - aluop 10, funct 101010 -> 0111 (slt).
  - aluop 10, funct 100111 -> 1100 (nor).
  - Any other funct with aluop 10 -> control 0010, illegal = 1, regwrite forced to 0.
- Operands:
  - src1 = rs_data.
  - src2 = alusrc ? sign-extended imm : rt_data. Sign extension replicates imm[IMM_W-1].
- Storage:
  - Main register drives all out_* signals; a skid register sits behind it.
  - in_ready is registered: in_ready = ~skid_valid.
  - Accept occurs when in_valid & in_ready. Drain occurs when out_valid & out_ready.
- Per-cycle update, in priority order:
  - flush: main and skid both invalid; any same-cycle accept is discarded; in_ready = 1 next cycle.
  - Main empty or draining:
    - skid valid -> skid moves to main, skid clears.
    - else accept -> main loads the decoded input.
    - else main goes invalid.
  - Main full, not draining, accept -> skid loads the decoded input.
  - Otherwise hold. Held outputs must stay stable while out_valid & ~out_ready.
- Latency 1 cycle from accept to out_valid. Throughput 1 instruction per cycle when out_ready stays high.
- Order is strictly FIFO. At most 2 entries are held; with both full, in_ready = 0.
- Simultaneous accept and drain with skid empty: the new instruction replaces main in the same edge, with no bubble.
- Fields of invalid entries are don't-care, but must not be X after reset.

Test Plan:
- Reset: assert rst_n low mid-transfer -> out_valid = 0, out_alu_control = 0000, in_ready = 1 after release.
- Decode sweep, out_ready = 1, one R-type per cycle:
  - funct 100000/100010/100100/100101/101010/100111 -> out_alu_control 0010/0110/0000/0001/0111/1100, each 1 cycle after its accept.
  - funct 000000 -> out_illegal = 1, out_regwrite = 0.
- Immediate: aluop 11, alusrc = 1, imm = 16'hFFFE, rs = 5 -> out_src2 = 32'hFFFFFFFE, out_src1 = 5, control 0111.
- Backpressure:
  - Hold out_ready = 0, offer A, B, C back-to-back -> A and B accepted; in_ready drops to 0 the cycle after B; C waits; out_* stays A.
  - Raise out_ready -> A, B, C emerge in order on consecutive cycles, no duplicates.
- Flush: two entries held, assert flush together with in_valid -> next cycle out_valid = 0, in_ready = 1, and the flushed-cycle instruction never appears.
- Streaming: 100 random instructions with random out_ready -> scoreboard matches decoded sequence exactly and out_* is stable whenever out_valid & ~out_ready.
